ascii_symbol_packer: RTL

- Sequential, parametrised successor to the 6-bit-to-ASCII character mapper.
- Consumes wide random/hash words over a valid/ready handshake and slices each into 6-bit symbols, LSB-first.
- Maps each symbol to ASCII through the team's standard 64-entry table; an alphabet mode rejects out-of-range symbols.
- Packs a programmable number of characters into an output string register for the password/message front-end feeding the SHA-256 core.

---
 rtl/ascii_symbol_packer.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ascii_symbol_packer.sv
// ascii_symbol_packer
// Slices wide source words into 6-bit symbols (LSB first), maps each symbol to
// a printable ASCII character and packs a programmable number of characters
// into a string register for the password/message front-end.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begin a new string (sampled only while idle)
//   mode       alphabet: 0 full table, 1 alphanumeric, 2 lowercase, 3 as 0
//   len        requested character count, clamped to MAX_CHARS
//   word_in    source word, word_valid qualifies it
//   word_ready high while the block is waiting for a source word
//   ascii_out  packed string, char i at bits [8i+7:8i]
//   char_count characters written so far
//   busy       high whenever the block is not idle
//   done       one-cycle pulse when the string is complete
module ascii_symbol_packer #(
    parameter int IN_W      = 32,
    parameter int MAX_CHARS = 16,
    parameter int LEN_W     = $clog2(MAX_CHARS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [LEN_W-1:0]       len,
    input  logic [IN_W-1:0]        word_in,
    input  logic                   word_valid,
    output logic                   word_ready,
    output logic [8*MAX_CHARS-1:0] ascii_out,
    output logic [LEN_W-1:0]       char_count,
    output logic                   busy,
    output logic                   done
);

    localparam int SYM_PER_WORD = IN_W / 6;
    localparam int IDX_W        = (SYM_PER_WORD > 1) ? $clog2(SYM_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYM_PER_WORD - 1);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_CHARS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Standard 64-entry symbol table: letters, digits, then punctuation.
    function automatic logic [7:0] sym_to_ascii(input logic [5:0] sym);
        logic [7:0] c;
        if (sym < 6'd26) begin
            c = 8'h61 + {2'b00, sym};
        end else if (sym < 6'd36) begin
            c = 8'h30 + ({2'b00, sym} - 8'd26);
        end else begin
            case (sym)
                6'd36:   c = 8'h21; // !
                6'd37:   c = 8'h40; // @
                6'd38:   c = 8'h23; // #
                6'd39:   c = 8'h24; // $
                6'd40:   c = 8'h25; // %
                6'd41:   c = 8'h5E; // ^
                6'd42:   c = 8'h26; // &
                6'd43:   c = 8'h2A; // *
                6'd44:   c = 8'h28; // (
                6'd45:   c = 8'h29; // )
                6'd46:   c = 8'h2D; // -
                6'd47:   c = 8'h5F; // _
                6'd48:   c = 8'h3D; // =
                6'd49:   c = 8'h2B; // +
                6'd50:   c = 8'h5B; // [
                6'd51:   c = 8'h5D; // ]
                6'd52:   c = 8'h7B; // {
                6'd53:   c = 8'h7D; // }
                6'd54:   c = 8'h3B; // ;
                6'd55:   c = 8'h3A; // :
                6'd56:   c = 8'h27; // '
                6'd57:   c = 8'h22; // "
                6'd58:   c = 8'h2C; // ,
                6'd59:   c = 8'h2E; // .
                6'd60:   c = 8'h3C; // <
                6'd61:   c = 8'h3E; // >
                6'd62:   c = 8'h2F; // /
                default: c = 8'h3F; // ?
            endcase
        end
        return c;
    endfunction

    // Alphabet filter; the reserved mode behaves as the full table.
    function automatic logic sym_accepted(input logic [1:0] m, input logic [5:0] sym);
        logic ok;
        case (m)
            2'd1:    ok = (sym < 6'd36);
            2'd2:    ok = (sym < 6'd26);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    state_t                 state_r;
    state_t                 state_next_s;
    logic [1:0]             mode_r;
    logic [LEN_W-1:0]       len_eff_r;
    logic [IN_W-1:0]        shreg_r;
    logic [IDX_W-1:0]       sym_idx_r;
    logic [8*MAX_CHARS-1:0] ascii_out_r;
    logic [LEN_W-1:0]       char_count_r;

    logic [5:0]             sym_s;
    logic                   write_s;
    logic                   last_char_s;
    logic                   last_sym_s;
    logic [LEN_W-1:0]       len_eff_s;

    // Symbol decode and completion conditions for the current EMIT cycle.
    always_comb begin
        sym_s       = shreg_r[5:0];
        write_s     = (state_r == EMIT) && sym_accepted(mode_r, sym_s);
        last_char_s = write_s && ((char_count_r + LEN_W'(1)) == len_eff_r);
        last_sym_s  = (sym_idx_r == LAST_IDX);
        len_eff_s   = (len > MAX_LEN) ? MAX_LEN : len;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; completing the string takes priority over refetching.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = (len_eff_s == {LEN_W{1'b0}}) ? DONE : FETCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: begin
                if (word_valid) begin
                    state_next_s = EMIT;
                end else begin
                    state_next_s = FETCH;
                end
            end
            EMIT: begin
                if (last_char_s) begin
                    state_next_s = DONE;
                end else if (last_sym_s) begin
                    state_next_s = FETCH;
                end else begin
                    state_next_s = EMIT;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Status outputs decoded from the state register only.
    always_comb begin
        word_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
            end
            FETCH: begin
                word_ready = 1'b1;
                busy       = 1'b1;
            end
            EMIT: begin
                busy = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath: request latch, word shift register and string packing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r       <= 2'd0;
            len_eff_r    <= {LEN_W{1'b0}};
            shreg_r      <= {IN_W{1'b0}};
            sym_idx_r    <= {IDX_W{1'b0}};
            ascii_out_r  <= {(8*MAX_CHARS){1'b0}};
            char_count_r <= {LEN_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mode_r       <= mode;
                        len_eff_r    <= len_eff_s;
                        ascii_out_r  <= {(8*MAX_CHARS){1'b0}};
                        char_count_r <= {LEN_W{1'b0}};
                    end
                end
                FETCH: begin
                    if (word_valid) begin
                        shreg_r   <= word_in;
                        sym_idx_r <= {IDX_W{1'b0}};
                    end
                end
                EMIT: begin
                    shreg_r   <= shreg_r >> 3'd6;
                    sym_idx_r <= sym_idx_r + IDX_W'(1);
                    if (write_s) begin
                        // char_count never reaches len_eff here, so the slot is in range.
                        for (int i = 0; i < MAX_CHARS; i++) begin
                            if (char_count_r == LEN_W'(i)) begin
                                ascii_out_r[8*i +: 8] <= sym_to_ascii(sym_s);
                            end
                        end
                        char_count_r <= char_count_r + LEN_W'(1);
                    end
                end
                default: begin
                    shreg_r <= shreg_r;
                end
            endcase
        end
    end

    assign ascii_out  = ascii_out_r;
    assign char_count = char_count_r;

endmodule
